ctr_fifo_capture_top: RTL and testbench

- Self-contained capture harness with three stages: a free-running counter source, an AXI-stream FIFO, and a capture RAM of SAMP words.
- Used to check FIFO flag and count behaviour and end-to-end data ordering.
- Exposes the FIFO status flags and occupancy counts, a sticky capture-complete flag (vip_full), and a read port into the capture RAM.
- Interface: one clock; reset is synchronous and active-low.

---
 rtl/ctr_fifo_capture_top.sv | 139 +++++++++++++
 tb/tb_ctr_fifo_capture_top.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ctr_fifo_capture_top.sv
// Counter source -> FWFT stream FIFO -> capture RAM harness.
// Exposes FIFO flags/counts, sticky capture-complete and a RAM read port.
module ctr_fifo_capture_top #(
    parameter int SAMP              = 32,
    parameter int TDATA_WIDTH       = 16,
    parameter int FIFO_DEPTH        = 128,
    parameter int PROG_FULL_THRESH  = 64,
    parameter int PROG_EMPTY_THRESH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          vip_full,
    output logic                          almost_empty_axis,
    output logic                          almost_full_axis,
    output logic                          prog_empty_axis,
    output logic                          prog_full_axis,
    output logic [$clog2(FIFO_DEPTH)-1:0] rd_data_count_axis,
    output logic [$clog2(FIFO_DEPTH)-1:0] wr_data_count_axis,
    input  logic [$clog2(SAMP)-1:0]       cap_addr,
    output logic [31:0]                   cap_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SAMP);

    logic [TDATA_WIDTH-1:0] cnt;
    logic                   src_tvalid;
    logic                   src_tready;
    logic                   push;

    logic [TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [AW-1:0]          occ;
    logic [AW-1:0]          occ_nxt;
    logic                   fifo_full;
    logic                   m_tvalid;
    logic [TDATA_WIDTH-1:0] m_tdata;

    logic                   drain_en;
    logic                   snk_tready;
    logic                   pop;
    logic [CW-1:0]          cap_ptr;
    logic [TDATA_WIDTH-1:0] ram [SAMP];
    logic [31:0]            rd_ext;

    assign src_tvalid = rst;
    assign fifo_full  = (occ == AW'(FIFO_DEPTH - 1));
    assign src_tready = !fifo_full;
    assign push       = src_tvalid & src_tready;

    assign m_tvalid   = (occ != '0);
    assign m_tdata    = mem[rptr];
    assign snk_tready = drain_en & !vip_full;
    assign pop        = rst & m_tvalid & snk_tready;

    assign rd_data_count_axis = occ;
    assign wr_data_count_axis = occ;

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + AW'(1);
            2'b01:   occ_nxt = occ - AW'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                cnt  <= cnt + TDATA_WIDTH'(1);
                wptr <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            occ <= occ_nxt;
        end
    end

    // Flags track the post-edge occupancy so they line up with the counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            almost_empty_axis <= 1'b1;
            prog_empty_axis   <= 1'b1;
            almost_full_axis  <= 1'b0;
            prog_full_axis    <= 1'b0;
        end else begin
            almost_empty_axis <= (occ_nxt <= AW'(1));
            prog_empty_axis   <= (occ_nxt <= AW'(PROG_EMPTY_THRESH));
            almost_full_axis  <= (occ_nxt >= AW'(FIFO_DEPTH - 2));
            prog_full_axis    <= (occ_nxt >= AW'(PROG_FULL_THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drain_en <= 1'b0;
            cap_ptr  <= '0;
            vip_full <= 1'b0;
        end else begin
            if (prog_full_axis)
                drain_en <= 1'b1;
            if (pop) begin
                cap_ptr <= cap_ptr + CW'(1);
                if (cap_ptr == CW'(SAMP - 1))
                    vip_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop)
            ram[cap_ptr] <= m_tdata;
    end

    always_comb begin
        rd_ext = '0;
        rd_ext[TDATA_WIDTH-1:0] = ram[cap_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cap_data <= '0;
        else
            cap_data <= rd_ext;
    end

endmodule

// File: tb/tb_ctr_fifo_capture_top.sv
// Scoreboard bench: queue-based reference model drives expectations,
// a monitor compares two parameterisations of the harness every cycle.
module tb_ctr_fifo_capture_top;

    typedef struct {
        int occ;
        bit ae;
        bit af;
        bit pe;
        bit pf;
        bit vip;
        bit cchk;
        int cval;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  addr0;
    logic [1:0]  addr1;

    logic        vip0, ae0, af0, pe0, pf0;
    logic [6:0]  rdc0, wrc0;
    logic [31:0] cd0;
    logic        vip1, ae1, af1, pe1, pf1;
    logic [3:0]  rdc1, wrc1;
    logic [31:0] cd1;

    int nchk = 0;
    int nerr = 0;

    exp_t exp_q [2][$];
    int   fq    [2][$];
    int   cnt   [2];
    bit   drn   [2];
    bit   vip   [2];
    int   ptr   [2];
    int   ram   [2][32];
    bit   rv    [2][32];

    ctr_fifo_capture_top u0 (
        .clk                (clk),
        .rst                (rst),
        .vip_full           (vip0),
        .almost_empty_axis  (ae0),
        .almost_full_axis   (af0),
        .prog_empty_axis    (pe0),
        .prog_full_axis     (pf0),
        .rd_data_count_axis (rdc0),
        .wr_data_count_axis (wrc0),
        .cap_addr           (addr0),
        .cap_data           (cd0)
    );

    ctr_fifo_capture_top #(
        .SAMP              (4),
        .TDATA_WIDTH       (16),
        .FIFO_DEPTH        (16),
        .PROG_FULL_THRESH  (8),
        .PROG_EMPTY_THRESH (3)
    ) u1 (
        .clk                (clk),
        .rst                (rst),
        .vip_full           (vip1),
        .almost_empty_axis  (ae1),
        .almost_full_axis   (af1),
        .prog_empty_axis    (pe1),
        .prog_full_axis     (pf1),
        .rd_data_count_axis (rdc1),
        .wr_data_count_axis (wrc1),
        .cap_addr           (addr1),
        .cap_data           (cd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int i);
        return (i == 0) ? 128 : 16;
    endfunction
    function automatic int pft(input int i);
        return (i == 0) ? 64 : 8;
    endfunction
    function automatic int pet(input int i);
        return (i == 0) ? 8 : 3;
    endfunction
    function automatic int samp(input int i);
        return (i == 0) ? 32 : 4;
    endfunction

    // Reference: FIFO is a queue; sink drains once occupancy has reached
    // the prog-full level, capturing SAMP words in arrival order.
    task automatic step(input int i, input bit r, input int a);
        exp_t e;
        int   sz;
        int   v;
        bit   psh;
        bit   pp;
        e.cchk = 1'b0;
        e.cval = 0;
        if (!r) begin
            fq[i].delete();
            cnt[i] = 0;
            drn[i] = 1'b0;
            vip[i] = 1'b0;
            ptr[i] = 0;
            e.cchk = 1'b1;
        end else begin
            sz     = fq[i].size();
            e.cchk = rv[i][a];
            e.cval = ram[i][a];
            psh    = (sz != dep(i) - 1);
            pp     = (sz != 0) && drn[i] && !vip[i];
            if (sz >= pft(i))
                drn[i] = 1'b1;
            if (pp) begin
                v = fq[i].pop_front();
                ram[i][ptr[i]] = v;
                rv[i][ptr[i]]  = 1'b1;
                ptr[i]++;
                if (ptr[i] == samp(i))
                    vip[i] = 1'b1;
            end
            if (psh) begin
                fq[i].push_back(cnt[i]);
                cnt[i] = (cnt[i] + 1) % 65536;
            end
        end
        sz    = fq[i].size();
        e.occ = sz;
        e.ae  = (sz <= 1);
        e.af  = (sz >= dep(i) - 2);
        e.pe  = (sz <= pet(i));
        e.pf  = (sz >= pft(i));
        e.vip = vip[i];
        exp_q[i].push_back(e);
    endtask

    task automatic cyc(input bit r, input int a);
        @(negedge clk);
        rst   = r;
        addr0 = 5'(a % 32);
        addr1 = 2'(a % 4);
        step(0, r, a % 32);
        step(1, r, a % 4);
    endtask

    task automatic chk(input string n, input int i, input int got, input int ex);
        nchk++;
        if (got != ex) begin
            nerr++;
            $display("FAIL %s u%0d: got %0d expected %0d", n, i, got, ex);
        end
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() != 0) begin
                    e = exp_q[i].pop_front();
                    chk("rd_count", i, (i == 0) ? int'(rdc0) : int'(rdc1), e.occ);
                    chk("wr_count", i, (i == 0) ? int'(wrc0) : int'(wrc1), e.occ);
                    chk("almost_empty", i, (i == 0) ? int'(ae0) : int'(ae1), int'(e.ae));
                    chk("almost_full", i, (i == 0) ? int'(af0) : int'(af1), int'(e.af));
                    chk("prog_empty", i, (i == 0) ? int'(pe0) : int'(pe1), int'(e.pe));
                    chk("prog_full", i, (i == 0) ? int'(pf0) : int'(pf1), int'(e.pf));
                    chk("vip_full", i, (i == 0) ? int'(vip0) : int'(vip1), int'(e.vip));
                    if (e.cchk)
                        chk("cap_data", i, (i == 0) ? int'(cd0) : int'(cd1), e.cval);
                end
            end
        end
    end

    initial begin : drv
        int n;
        rst   = 1'b0;
        addr0 = '0;
        addr1 = '0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 32; k++)
                rv[i][k] = 1'b0;

        repeat (10) cyc(1'b0, int'($urandom_range(0, 31)));
        repeat (200) cyc(1'b1, int'($urandom_range(0, 31)));
        for (int k = 0; k < 34; k++)
            cyc(1'b1, k);

        repeat (2) cyc(1'b0, int'($urandom_range(0, 31)));
        n = 70 + int'($urandom_range(0, 20));
        repeat (n) cyc(1'b1, int'($urandom_range(0, 31)));
        n = 1 + int'($urandom_range(0, 2));
        repeat (n) cyc(1'b0, int'($urandom_range(0, 31)));
        repeat (200) cyc(1'b1, int'($urandom_range(0, 31)));
        for (int k = 0; k < 34; k++)
            cyc(1'b1, k);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("leftover", i, exp_q[i].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
